// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
//   Shares one fp_mul single-precision multiplier between N requesters.
//   Round-robin grant in IDLE, operands held on the multiplier for
//   MUL_LATENCY cycles, product returned to the granted requester with a
//   valid/ready handshake. One operation in flight at a time; the product
//   passes through bit-exact.
//
// Ports
//   clk, rstn              clock, async active-low reset
//   req_valid/req_ready    per-requester operand handshake (ready one-hot)
//   req_num1/req_num2      per-requester operands, IEEE-754 single
//   rsp_valid/rsp_ready    per-requester result handshake (valid one-hot)
//   rsp_data               product, shared, qualified by rsp_valid
//   mul_num1/mul_num2      operands to the multiplier
//   mul_s                  product from the multiplier
//   busy                   FSM not in IDLE
//
// state  | meaning
// IDLE   | searching for a requester from ptr upward, accept on handshake
// MUL    | operands held on the multiplier, cnt counting down
// RESP   | product held, rsp_valid to the granted requester

module fp_mul_arbiter #(
    parameter int N           = 2,
    parameter int MUL_LATENCY = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    input  logic [N-1:0][31:0] req_num1,
    input  logic [N-1:0][31:0] req_num2,
    output logic [N-1:0]       rsp_valid,
    input  logic [N-1:0]       rsp_ready,
    output logic [31:0]        rsp_data,
    output logic [31:0]        mul_num1,
    output logic [31:0]        mul_num2,
    input  logic [31:0]        mul_s,
    output logic               busy
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(MUL_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] gnt_idx_q;
    logic [PW-1:0] gnt_idx_d;
    logic [CW-1:0] cnt_q;
    logic [31:0]   op1_q;
    logic [31:0]   op2_q;
    logic [31:0]   op1_d;
    logic [31:0]   op2_d;
    logic [31:0]   rsp_data_q;
    logic          gnt_ok;
    logic          rsp_hs;

    // Rotating priority as two passes: indices at or above ptr first, then
    // the ones below it. This wraps correctly for any N, power of 2 or not.
    always_comb begin
        gnt_ok    = 1'b0;
        gnt_idx_d = '0;
        for (int i = 0; i < N; i++) begin
            if (!gnt_ok && req_valid[i] && (i >= int'(ptr_q))) begin
                gnt_ok    = 1'b1;
                gnt_idx_d = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!gnt_ok && req_valid[i] && (i < int'(ptr_q))) begin
                gnt_ok    = 1'b1;
                gnt_idx_d = PW'(i);
            end
        end
    end

    always_comb begin
        op1_d = '0;
        op2_d = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx_d == PW'(i)) begin
                op1_d = req_num1[i];
                op2_d = req_num2[i];
            end
        end
    end

    // req_ready is gated by rstn so it reads zero while reset is held even
    // if a requester is already presenting.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < N; i++) begin
            req_ready[i] = rstn && (state_q == S_IDLE) && gnt_ok && (gnt_idx_d == PW'(i));
            rsp_valid[i] = (state_q == S_RESP) && (gnt_idx_q == PW'(i));
        end
    end

    assign rsp_hs   = |(rsp_valid & rsp_ready);
    assign ptr_d    = (gnt_idx_q == PW'(N - 1)) ? '0 : gnt_idx_q + PW'(1);
    assign busy     = (state_q != S_IDLE);
    assign mul_num1 = op1_q;
    assign mul_num2 = op2_q;
    assign rsp_data = rsp_data_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            gnt_idx_q  <= '0;
            cnt_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_ok) begin
                        op1_q     <= op1_d;
                        op2_q     <= op2_d;
                        gnt_idx_q <= gnt_idx_d;
                        cnt_q     <= CW'(MUL_LATENCY);
                        state_q   <= S_MUL;
                    end
                end
                S_MUL: begin
                    cnt_q <= cnt_q - CW'(1);
                    // Last MUL cycle: the multiplier output has had the full
                    // latency window with stable operands.
                    if (cnt_q == CW'(1)) begin
                        rsp_data_q <= mul_s;
                        state_q    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_hs) begin
                        ptr_q   <= ptr_d;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
module tb_fp_mul_arbiter;

    localparam int LA = 8;
    localparam int LB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    logic [1:0]       a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [1:0][31:0] a_req_num1, a_req_num2;
    logic [31:0]      a_rsp_data, a_mul_num1, a_mul_num2, a_mul_s;
    logic             a_busy;

    logic [2:0]       b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [2:0][31:0] b_req_num1, b_req_num2;
    logic [31:0]      b_rsp_data, b_mul_num1, b_mul_num2, b_mul_s;
    logic             b_busy;

    int checks = 0;
    int failures = 0;

    fp_mul_arbiter #(.N(2), .MUL_LATENCY(LA)) u_dut_a (
        .clk(clk), .rstn(rstn),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_num1(a_req_num1), .req_num2(a_req_num2),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
        .mul_num1(a_mul_num1), .mul_num2(a_mul_num2), .mul_s(a_mul_s),
        .busy(a_busy)
    );

    fp_mul_arbiter #(.N(3), .MUL_LATENCY(LB)) u_dut_b (
        .clk(clk), .rstn(rstn),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_num1(b_req_num1), .req_num2(b_req_num2),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .mul_num1(b_mul_num1), .mul_num2(b_mul_num2), .mul_s(b_mul_s),
        .busy(b_busy)
    );

    // Multiplier stand-in: a few real IEEE-754 products, a hash otherwise.
    function automatic logic [31:0] mul_fn(input logic [31:0] x, input logic [31:0] y);
        case ({x, y})
            {32'h3FC00000, 32'h40000000}: return 32'h40400000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            {32'h3F800000, 32'hBF800000}: return 32'hBF800000;
            {32'h3F000000, 32'h40800000}: return 32'h40000000;
            default: return x ^ {y[15:0], y[31:16]} ^ 32'h13579BDF;
        endcase
    endfunction

    // Product is only correct once operands have been stable for the full
    // latency (counting the cycle they appear); earlier it is garbage.
    int          a_stab = 0, b_stab = 0;
    logic [31:0] a_p1 = '0, a_p2 = '0, b_p1 = '0, b_p2 = '0;
    always @(negedge clk) begin
        if (a_mul_num1 === a_p1 && a_mul_num2 === a_p2) a_stab <= a_stab + 1;
        else a_stab <= 1;
        a_p1 <= a_mul_num1;
        a_p2 <= a_mul_num2;
        if (b_mul_num1 === b_p1 && b_mul_num2 === b_p2) b_stab <= b_stab + 1;
        else b_stab <= 1;
        b_p1 <= b_mul_num1;
        b_p2 <= b_mul_num2;
    end
    assign a_mul_s = (a_stab >= LA) ? mul_fn(a_mul_num1, a_mul_num2) : ~mul_fn(a_mul_num1, a_mul_num2);
    assign b_mul_s = (b_stab >= LB) ? mul_fn(b_mul_num1, b_mul_num2) : ~mul_fn(b_mul_num1, b_mul_num2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge of the first MUL cycle.
    task automatic a_issue(input int who, input logic [31:0] x, input logic [31:0] y);
        bit got;
        got = 1'b0;
        a_req_valid[who] = 1'b1;
        a_req_num1[who]  = x;
        a_req_num2[who]  = y;
        for (int k = 0; k < 40 && !got; k++) begin
            #1;
            if (a_req_ready[who]) got = 1'b1;
            else @(negedge clk);
        end
        chk("issue_grant", 32'(a_req_ready), 32'(1 << who));
        @(posedge clk);
        @(negedge clk);
        a_req_valid[who] = 1'b0;
    endtask

    // Returns #1 after the negedge of the first RESP cycle.
    task automatic a_wait_rsp(input int who, input logic [31:0] exp);
        int lat;
        bit got;
        lat = 1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            #1;
            if (a_rsp_valid != 0) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk("rsp_latency", 32'(lat), 32'(LA + 1));
        chk("rsp_onehot", 32'(a_rsp_valid), 32'(1 << who));
        chk("rsp_data", a_rsp_data, exp);
        chk("rsp_busy", 32'(a_busy), 32'd1);
    endtask

    // Valids set by caller and kept asserted; checks the grant order, then drains.
    task automatic a_grant_seq(input int n, input int s0, input int s1, input int s2);
        int seq[3];
        bit got;
        seq = '{s0, s1, s2};
        for (int j = 0; j < n; j++) begin
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                #1;
                if (a_req_ready != 0) got = 1'b1;
                else @(negedge clk);
            end
            chk($sformatf("grant_order_%0d", j), 32'(a_req_ready), 32'(1 << seq[j]));
            @(posedge clk);
            @(negedge clk);
            a_req_num1[seq[j]] = $urandom;
            a_req_num2[seq[j]] = $urandom;
        end
        a_req_valid = '0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            #1;
            if (!a_busy) got = 1'b1;
            else @(negedge clk);
        end
        chk("drain_idle", 32'(a_busy), 32'd0);
    endtask

    typedef struct {
        int          who;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prod;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[4];
        int          bseq[4];
        logic [31:0] x, y;
        bit          bad, got, m_busy, hs_now, rsp_now;
        int          m_owner, m_hs, m_ptr, cyc, kk, exp_idx, idx, drop_idx, lat, e;
        logic [31:0] m_op1, m_op2;

        vecs[0] = '{0, 32'h3FC00000, 32'h40000000, 32'h40400000};
        vecs[1] = '{1, 32'h40000000, 32'h40000000, 32'h40800000};
        vecs[2] = '{0, 32'h3F800000, 32'hBF800000, 32'hBF800000};
        vecs[3] = '{1, 32'h3F000000, 32'h40800000, 32'h40000000};
        bseq = '{0, 1, 2, 0};

        rstn = 1'b0;
        a_req_valid = '0; a_rsp_ready = '1; a_req_num1 = '0; a_req_num2 = '0;
        b_req_valid = '0; b_rsp_ready = '1; b_req_num1 = '0; b_req_num2 = '0;

        @(negedge clk);
        #1;
        chk("reset_busy", 32'(a_busy), 32'd0);
        chk("reset_req_ready", 32'(a_req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("reset_mul_num1", a_mul_num1, 32'd0);
        chk("reset_mul_num2", a_mul_num2, 32'd0);
        chk("reset_rsp_data", a_rsp_data, 32'd0);
        chk("reset_b_busy", 32'(b_busy), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // single operations from a table
        for (int i = 0; i < 4; i++) begin
            a_issue(vecs[i].who, vecs[i].a, vecs[i].b);
            a_wait_rsp(vecs[i].who, vecs[i].prod);
            @(negedge clk);
            #1;
            chk("idle_after_rsp", 32'(a_busy), 32'd0);
            @(negedge clk);
        end

        // contention from reset: 0, then 1, then 1 again beats 0 is not expected:
        // ptr after serving 1 is 0, so sequence is 0,1,0
        do_reset();
        a_req_num1 = {32'h40000000, 32'h3FC00000};
        a_req_num2 = {32'h40000000, 32'h40000000};
        a_req_valid = 2'b11;
        a_grant_seq(3, 0, 1, 0);

        // operand stability during MUL, requests ignored
        @(negedge clk);
        x = 32'h3F800000; y = 32'hBF800000;
        a_issue(0, x, y);
        a_req_valid[1] = 1'b1;
        for (int m = 0; m < LA; m++) begin
            a_req_num1 = {$urandom, $urandom};
            a_req_num2 = {$urandom, $urandom};
            #1;
            chk("hold_mul_num1", a_mul_num1, x);
            chk("hold_mul_num2", a_mul_num2, y);
            chk("mul_no_ready", 32'(a_req_ready), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("hold_rsp_valid", 32'(a_rsp_valid), 32'd1);
        chk("hold_rsp_data", a_rsp_data, mul_fn(x, y));
        a_req_valid[1] = 1'b0;
        @(negedge clk);

        // response backpressure; ptr is now 1, req0 wins by wrap-around
        a_rsp_ready = 2'b10;
        x = 32'h3F000000; y = 32'h40800000;
        a_issue(0, x, y);
        a_wait_rsp(0, 32'h40000000);
        a_req_valid[1] = 1'b1;
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            #1;
            chk("bp_rsp_valid", 32'(a_rsp_valid), 32'd1);
            chk("bp_rsp_data", a_rsp_data, 32'h40000000);
            chk("bp_busy", 32'(a_busy), 32'd1);
            chk("bp_no_grant", 32'(a_req_ready), 32'd0);
        end
        @(negedge clk);
        a_rsp_ready = 2'b11;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("bp_released", 32'(a_rsp_valid), 32'd0);
        chk("bp_next_grant", 32'(a_req_ready), 32'd2);
        a_req_valid[1] = 1'b0;
        #1;
        chk("drop_no_ready", 32'(a_req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("drop_nothing_latched", 32'(a_busy), 32'd0);

        // reset three cycles into MUL; ptr is 1 beforehand
        @(negedge clk);
        a_issue(0, 32'h40000000, 32'h40000000);
        @(negedge clk);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(a_req_ready), 32'd0);
        chk("rst_mul_num1", a_mul_num1, 32'd0);
        chk("rst_mul_num2", a_mul_num2, 32'd0);
        chk("rst_rsp_data", a_rsp_data, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        bad = 1'b0;
        for (int m = 0; m < 12; m++) begin
            @(negedge clk);
            #1;
            if (a_rsp_valid != 0 || a_busy) bad = 1'b1;
        end
        chk("no_rsp_after_reset", 32'(bad), 32'd0);
        @(negedge clk);
        a_req_valid = 2'b11;
        a_grant_seq(2, 0, 1, 0);

        // randomized traffic against a transaction-timing model
        do_reset();
        a_req_valid = '0;
        m_busy = 1'b0; m_ptr = 0; cyc = 0; m_hs = 0; m_owner = 0;
        m_op1 = '0; m_op2 = '0; drop_idx = -1;
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            if (drop_idx >= 0) a_req_valid[drop_idx] = 1'b0;
            drop_idx = -1;
            for (int i = 0; i < 2; i++) begin
                if (!a_req_valid[i] && $urandom_range(0, 3) == 0) begin
                    a_req_valid[i] = 1'b1;
                    a_req_num1[i]  = $urandom;
                    a_req_num2[i]  = $urandom;
                end
            end
            a_rsp_ready = 2'($urandom);
            #1;
            hs_now = 1'b0;
            rsp_now = 1'b0;
            kk = cyc - m_hs;
            if (!m_busy) begin
                exp_idx = -1;
                for (int k = 0; k < 2; k++) begin
                    idx = (m_ptr + k) % 2;
                    if (exp_idx < 0 && a_req_valid[idx]) exp_idx = idx;
                end
                chk("rnd_ready", 32'(a_req_ready), (exp_idx < 0) ? 32'd0 : 32'(1 << exp_idx));
                chk("rnd_idle_busy", 32'(a_busy), 32'd0);
                chk("rnd_idle_rsp", 32'(a_rsp_valid), 32'd0);
                if (exp_idx >= 0) begin
                    hs_now  = 1'b1;
                    m_owner = exp_idx;
                    m_op1   = a_req_num1[exp_idx];
                    m_op2   = a_req_num2[exp_idx];
                end
            end else begin
                chk("rnd_busy", 32'(a_busy), 32'd1);
                chk("rnd_no_ready", 32'(a_req_ready), 32'd0);
                if (kk <= LA) begin
                    chk("rnd_mul_rsp", 32'(a_rsp_valid), 32'd0);
                    chk("rnd_mul_num1", a_mul_num1, m_op1);
                    chk("rnd_mul_num2", a_mul_num2, m_op2);
                end else begin
                    chk("rnd_rsp_valid", 32'(a_rsp_valid), 32'(1 << m_owner));
                    chk("rnd_rsp_data", a_rsp_data, mul_fn(m_op1, m_op2));
                    rsp_now = a_rsp_ready[m_owner];
                end
            end
            @(posedge clk);
            if (hs_now) begin
                m_busy   = 1'b1;
                m_hs     = cyc;
                drop_idx = m_owner;
            end
            if (rsp_now) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % 2;
            end
            cyc++;
        end
        @(negedge clk);
        a_req_valid = '0;

        // N=3, MUL_LATENCY=1, all requesters valid
        @(negedge clk);
        b_rsp_ready = '1;
        for (int i = 0; i < 3; i++) begin
            b_req_num1[i] = $urandom;
            b_req_num2[i] = $urandom;
        end
        b_req_valid = 3'b111;
        for (int j = 0; j < 4; j++) begin
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                #1;
                if (b_req_ready != 0) got = 1'b1;
                else @(negedge clk);
            end
            e = bseq[j];
            chk($sformatf("n3_grant_%0d", j), 32'(b_req_ready), 32'(1 << e));
            x = b_req_num1[e];
            y = b_req_num2[e];
            @(posedge clk);
            @(negedge clk);
            b_req_num1[e] = $urandom;
            b_req_num2[e] = $urandom;
            if (j == 3) b_req_valid = '0;
            lat = 1;
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                #1;
                if (b_rsp_valid != 0) got = 1'b1;
                else begin
                    @(negedge clk);
                    lat++;
                end
            end
            chk("n3_latency", 32'(lat), 32'(LB + 1));
            chk("n3_rsp_onehot", 32'(b_rsp_valid), 32'(1 << e));
            chk("n3_rsp_data", b_rsp_data, mul_fn(x, y));
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
